pc_fetch_unit: RTL

//  Program counter and instruction fetch stage directly upstream of the control FSM.

---
 rtl/pc_fetch_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction fetch stage sitting directly upstream of the
// control FSM. It holds the PC, applies the FSM's update commands (increment,
// PC-relative branch, register jump) and fetches instruction words from
// instruction memory over a req/ack handshake.
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   : saturating taken / not-taken branch counters are built.
//   undefined : no counter registers; both counter ports are driven 16'h0000.
//
// Parameters
//   ADDR_W    PC / instruction address width (<= 16)
//   INSTR_W   instruction word width
//   RESET_PC  PC value loaded during reset
//
// Ports
//   Clk         in   system clock, all state updates on posedge
//   Reset_n     in   asynchronous active-low reset
//   PCEn        in   PC update strobe from the control FSM
//   PCState     in   00=PC+1, 01=PC+sext(Imm), 10=RsrcData, 11=PC+1 (not taken)
//   Imm         in   signed 8-bit branch displacement
//   RsrcData    in   register-file value used as jump target
//   MemData     in   instruction word from memory
//   MemAck      in   MemData valid for the current request
//   MemReq      out  fetch request, held until MemAck (registered)
//   InstrAddr   out  fetch address, equal to PC
//   Instr       out  latched instruction (registered)
//   InstrValid  out  Instr corresponds to the current PC (registered)
//   PC          out  current PC (registered)
//   PCPlus1     out  PC+1 zero-extended to 16 bits, link value
//   BrTakenCnt  out  taken branch/jump count
//   BrNTakenCnt out  not-taken branch count
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int          ADDR_W   = 16,
    parameter int          INSTR_W  = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               PCEn,
    input  logic [1:0]         PCState,
    input  logic [7:0]         Imm,
    input  logic [15:0]        RsrcData,
    input  logic [INSTR_W-1:0] MemData,
    input  logic               MemAck,
    output logic               MemReq,
    output logic [ADDR_W-1:0]  InstrAddr,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    output logic [ADDR_W-1:0]  PC,
    output logic [15:0]        PCPlus1,
    output logic [15:0]        BrTakenCnt,
    output logic [15:0]        BrNTakenCnt
);

    localparam logic [1:0] ST_START = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;
    localparam logic [1:0] ST_DROP  = 2'b11;

    localparam logic [1:0] PCS_INC  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JMP  = 2'b10;
    localparam logic [1:0] PCS_NTK  = 2'b11;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1'b1);

    // Sign-extend the 8-bit displacement to the PC width.
    function automatic logic [ADDR_W-1:0] sext_imm(input logic [7:0] imm);
        return ADDR_W'($signed(imm));
    endfunction

    logic [1:0]         state_r;
    logic               armed_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] instr_r;
    logic               instr_valid_r;
    logic               mem_req_r;
    logic [ADDR_W-1:0]  pc_inc_s;
    logic [ADDR_W-1:0]  next_pc_s;

    // Next-PC selection; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        pc_inc_s  = pc_r + PC_ONE;
        next_pc_s = pc_inc_s;
        case (PCState)
            PCS_INC: next_pc_s = pc_inc_s;
            PCS_BR:  next_pc_s = pc_r + sext_imm(Imm);
            PCS_JMP: next_pc_s = RsrcData[ADDR_W-1:0];
            PCS_NTK: next_pc_s = pc_inc_s;
            default: next_pc_s = pc_inc_s;
        endcase
    end

    // Fetch FSM: PC register, request handshake and instruction latch.
    // START spends one full cycle after reset release (tracked by armed_r)
    // before the first request is raised.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= ST_START;
            armed_r       <= 1'b0;
            pc_r          <= RESET_PC[ADDR_W-1:0];
            instr_r       <= {INSTR_W{1'b0}};
            instr_valid_r <= 1'b0;
            mem_req_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_START: begin
                    // PCEn is deliberately ignored here.
                    if (armed_r) begin
                        state_r   <= ST_FETCH;
                        mem_req_r <= 1'b1;
                    end else begin
                        armed_r <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // A PC update wins over a same-cycle ack: the in-flight
                    // word belongs to the old PC and is discarded.
                    if (PCEn) begin
                        pc_r          <= next_pc_s;
                        mem_req_r     <= 1'b0;
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_DROP;
                    end else if (MemAck) begin
                        instr_r       <= MemData;
                        instr_valid_r <= 1'b1;
                        mem_req_r     <= 1'b0;
                        state_r       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (PCEn) begin
                        pc_r          <= next_pc_s;
                        instr_valid_r <= 1'b0;
                        mem_req_r     <= 1'b1;
                        state_r       <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // One dead cycle lets memory see the request fall; a
                    // further PC update restarts that cycle.
                    if (PCEn) begin
                        pc_r <= next_pc_s;
                    end else begin
                        mem_req_r <= 1'b1;
                        state_r   <= ST_FETCH;
                    end
                end
                default: begin
                    state_r       <= ST_START;
                    armed_r       <= 1'b0;
                    mem_req_r     <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign MemReq     = mem_req_r;
    assign InstrAddr  = pc_r;
    assign Instr      = instr_r;
    assign InstrValid = instr_valid_r;
    assign PC         = pc_r;
    assign PCPlus1    = 16'(pc_inc_s);

`ifdef BRANCH_STATS_EN
    logic        pc_load_s;
    logic [15:0] br_taken_r;
    logic [15:0] br_ntaken_r;

    // A PC update is accepted in every state except START.
    always_comb begin
        if (state_r != ST_START) begin
            pc_load_s = PCEn;
        end else begin
            pc_load_s = 1'b0;
        end
    end

    // Saturating branch statistics, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            br_taken_r  <= 16'h0000;
            br_ntaken_r <= 16'h0000;
        end else if (pc_load_s) begin
            if (((PCState == PCS_BR) || (PCState == PCS_JMP)) && (br_taken_r != 16'hFFFF)) begin
                br_taken_r <= br_taken_r + 16'h0001;
            end
            if ((PCState == PCS_NTK) && (br_ntaken_r != 16'hFFFF)) begin
                br_ntaken_r <= br_ntaken_r + 16'h0001;
            end
        end
    end

    assign BrTakenCnt  = br_taken_r;
    assign BrNTakenCnt = br_ntaken_r;
`else
    assign BrTakenCnt  = 16'h0000;
    assign BrNTakenCnt = 16'h0000;
`endif

endmodule
